out_unit: RTL and testbench

//  MIX output unit, the transmit-side counterpart of the MIX input unit. On an OUT

---
 rtl/out_unit_pkg.sv | 48 ++++
 rtl/out_unit_uart_tx.sv | 49 ++++
 rtl/out_unit.sv | 163 ++++++++++++++++
 tb/tb_out_unit.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_unit_pkg.sv
// MIX character set constants, FSM state type and the MIX-to-ASCII mapping
// shared by the output unit and its bench.
package mix_charset;
   localparam int MIX_CHAR_W = 6;
   localparam int WORD_W     = 30;
   localparam int ADDR_W     = 12;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SEND,
      ST_EOL,
      ST_DONE
   } out_state_e;

   function automatic logic [7:0] mix2ascii(input logic [MIX_CHAR_W-1:0] c);
      logic [7:0] a;
      a = 8'h3F;
      case (c) inside
         6'd0:            a = 8'h20;
         [6'd1:6'd9]:     a = 8'h40 + {2'b00, c};
         [6'd11:6'd19]:   a = 8'h3F + {2'b00, c};
         [6'd22:6'd29]:   a = 8'h3D + {2'b00, c};
         [6'd30:6'd39]:   a = 8'h12 + {2'b00, c};
         6'd40:           a = 8'h2E;
         6'd41:           a = 8'h2C;
         6'd42:           a = 8'h28;
         6'd43:           a = 8'h29;
         6'd44:           a = 8'h2B;
         6'd45:           a = 8'h2D;
         6'd46:           a = 8'h2A;
         6'd47:           a = 8'h2F;
         6'd48:           a = 8'h3D;
         6'd49:           a = 8'h24;
         6'd50:           a = 8'h3C;
         6'd51:           a = 8'h3E;
         6'd52:           a = 8'h40;
         6'd53:           a = 8'h3B;
         6'd54:           a = 8'h3A;
         6'd55:           a = 8'h27;
         default:         a = 8'h3F;
      endcase
      return a;
   endfunction
endpackage

// File: rtl/out_unit_uart_tx.sv
// 8N1 UART transmitter, LSB first; ready is high whenever no frame is on the line.
module UartTX #(
   parameter int BAUD_DIV = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] in,
   output logic       tx,
   output logic       ready
);
   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_DIV - 1);

   logic          active;
   logic [8:0]    frame;
   logic [3:0]    bits_left;
   logic [CW-1:0] baud_cnt;

   // frame holds the data bits followed by the stop bit; tx already carries the start bit
   always_ff @(posedge clk) begin
      if (!reset) begin
         active    <= 1'b0;
         frame     <= '1;
         bits_left <= '0;
         baud_cnt  <= '0;
         tx        <= 1'b1;
      end else if (!active) begin
         if (start) begin
            active    <= 1'b1;
            tx        <= 1'b0;
            frame     <= {1'b1, in};
            bits_left <= 4'd9;
            baud_cnt  <= BAUD_LOAD;
         end
      end else if (baud_cnt != '0) begin
         baud_cnt <= baud_cnt - 1'b1;
      end else if (bits_left == 4'd0) begin
         active <= 1'b0;
      end else begin
         tx        <= frame[0];
         frame     <= {1'b1, frame[8:1]};
         bits_left <= bits_left - 1'b1;
         baud_cnt  <= BAUD_LOAD;
      end
   end

   assign ready = !active;
endmodule

// File: rtl/out_unit.sv
// MIX output unit: fetches a block of words from the CPU and sends each word as
// five ASCII characters over the UART, optionally followed by CR LF.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | no block in progress, waiting for start
//  FETCH    | request high, waiting for the CPU to load the word
//  SEND     | handing chars 0..4 of the current word to the UART
//  EOL      | handing CR then LF to the UART
//  DONE     | waiting for the UART to drain, then chain or go idle
module out_unit
   import mix_charset::*;
#(
   parameter int BLOCK_WORDS = 16,
   parameter int BAUD_DIV    = 104,
   parameter bit APPEND_EOL  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] addressin,
   output logic [11:0] addressout,
   input  logic [29:0] in,
   input  logic        load,
   output logic        request,
   output logic        stop,
   output logic        busy,
   output logic        tx
);
   localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

   out_state_e  state, state_n;
   logic        busy_n, request_n, stop_n, pending, pending_n, eol_sel, eol_sel_n;
   logic [11:0] addressout_n, next_addr, next_addr_n;
   logic [29:0] word, word_n;
   logic [3:0]  word_cnt, word_cnt_n;
   logic [2:0]  char_cnt, char_cnt_n;
   logic        uart_start, uart_ready;
   logic [7:0]  uart_data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         request    <= 1'b0;
         stop       <= 1'b0;
         addressout <= '0;
         next_addr  <= '0;
         pending    <= 1'b0;
         word       <= '0;
         word_cnt   <= '0;
         char_cnt   <= '0;
         eol_sel    <= 1'b0;
      end else begin
         state      <= state_n;
         busy       <= busy_n;
         request    <= request_n;
         stop       <= stop_n;
         addressout <= addressout_n;
         next_addr  <= next_addr_n;
         pending    <= pending_n;
         word       <= word_n;
         word_cnt   <= word_cnt_n;
         char_cnt   <= char_cnt_n;
         eol_sel    <= eol_sel_n;
      end
   end

   always_comb begin
      state_n      = state;
      busy_n       = busy;
      request_n    = request;
      stop_n       = 1'b0;
      addressout_n = addressout;
      next_addr_n  = next_addr;
      pending_n    = pending;
      word_n       = word;
      word_cnt_n   = word_cnt;
      char_cnt_n   = char_cnt;
      eol_sel_n    = eol_sel;
      uart_start   = 1'b0;
      uart_data    = mix2ascii(word[29:24]);

      // a start while busy queues one follow-on block; further starts are dropped
      if (busy && start && !pending) begin
         pending_n   = 1'b1;
         next_addr_n = addressin;
      end

      case (state)
         ST_IDLE: begin
            if (start) begin
               busy_n       = 1'b1;
               stop_n       = 1'b1;
               addressout_n = addressin;
               word_cnt_n   = '0;
               state_n      = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (!request) begin
               request_n = 1'b1;
            end else if (load) begin
               word_n       = in;
               request_n    = 1'b0;
               addressout_n = addressout + 1'b1;
               char_cnt_n   = '0;
               state_n      = ST_SEND;
            end
         end
         ST_SEND: begin
            if (uart_ready) begin
               uart_start = 1'b1;
               word_n     = {word[23:0], 6'b000000};
               if (char_cnt == 3'd4) begin
                  eol_sel_n = 1'b0;
                  if (word_cnt < LAST_WORD) begin
                     word_cnt_n = word_cnt + 1'b1;
                     state_n    = ST_FETCH;
                  end else begin
                     state_n = APPEND_EOL ? ST_EOL : ST_DONE;
                  end
               end else begin
                  char_cnt_n = char_cnt + 1'b1;
               end
            end
         end
         ST_EOL: begin
            uart_data = eol_sel ? ASCII_LF : ASCII_CR;
            if (uart_ready) begin
               uart_start = 1'b1;
               if (eol_sel) state_n = ST_DONE;
               else         eol_sel_n = 1'b1;
            end
         end
         ST_DONE: begin
            // a start arriving on the completing cycle chains just like a queued one
            if (uart_ready) begin
               if (pending || start) begin
                  addressout_n = pending ? next_addr : addressin;
                  pending_n    = 1'b0;
                  stop_n       = 1'b1;
                  word_cnt_n   = '0;
                  state_n      = ST_FETCH;
               end else begin
                  busy_n  = 1'b0;
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   UartTX #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
      .clk   (clk),
      .reset (reset),
      .start (uart_start),
      .in    (uart_data),
      .tx    (tx),
      .ready (uart_ready)
   );
endmodule

// File: tb/tb_out_unit.sv
// Scoreboard bench for out_unit: a CPU responder checks request addresses, a UART
// receiver checks every byte, and a stop monitor checks every stop pulse.
module tb_out_unit;
   localparam int BD = 8;
   localparam int BW = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [11:0] addressin = '0;
   logic [11:0] addressout;
   logic [29:0] cpu_word;
   logic        load;
   logic        request, stop, busy, tx;

   logic        load_resp = 1'b0, load_stray = 1'b0;
   logic [29:0] in_resp = '0, in_stray = '0;
   assign load     = load_resp | load_stray;
   assign cpu_word = load_stray ? in_stray : in_resp;

   always #5 clk = ~clk;

   out_unit #(.BLOCK_WORDS(BW), .BAUD_DIV(BD), .APPEND_EOL(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .addressin(addressin),
      .addressout(addressout), .in(cpu_word), .load(load), .request(request),
      .stop(stop), .busy(busy), .tx(tx)
   );

   typedef struct { logic [11:0] addr; int bytes; } stop_exp_t;

   int          n_checks = 0, n_pass = 0;
   logic [7:0]  exp_q[$];
   logic [11:0] addr_q[$];
   stop_exp_t   stop_q[$];
   logic [29:0] mem [logic [11:0]];
   int          bytes_seen = 0, frames_started = 0, abort_cnt = 0, busy_low_cnt = 0;
   bit          hold = 1'b0;
   int          resp_wait = 0, resp_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      n_checks++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   function automatic logic [29:0] mkw(input int c0, c1, c2, c3, c4);
      return {c0[5:0], c1[5:0], c2[5:0], c3[5:0], c4[5:0]};
   endfunction

   task automatic push_block(input logic [11:0] a, input logic [29:0] w0, input logic [29:0] w1);
      logic [11:0] a1;
      a1 = a + 12'd1;
      mem[a] = w0;
      mem[a1] = w1;
      addr_q.push_back(a);
      addr_q.push_back(a1);
   endtask

   task automatic push5(input logic [39:0] s);
      for (int i = 4; i >= 0; i--) exp_q.push_back(s[i*8 +: 8]);
   endtask

   task automatic push_eol();
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic do_start(input logic [11:0] a);
      @(negedge clk);
      addressin = a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle_start(input logic [11:0] a);
      stop_q.push_back('{addr: a, bytes: -1});
      do_start(a);
      check("stop_after_start", 32'(stop), 32'd1);
      check("busy_after_start", 32'(busy), 32'd1);
      check("addr_after_start", 32'(addressout), 32'(a));
      check("req_one_cycle_late", 32'(request), 32'd0);
      @(negedge clk);
      check("req_rise", 32'(request), 32'd1);
      check("stop_width", 32'(stop), 32'd0);
   endtask

   task automatic wait_bytes(input string name, input int n, input int budget);
      int k;
      k = 0;
      while (bytes_seen < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (bytes_seen < n) check(name, 32'(bytes_seen), 32'(n));
   endtask

   task automatic wait_done(input string name, input int budget);
      int k;
      k = 0;
      while ((busy || exp_q.size() != 0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, {31'd0, busy}, 32'd0);
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   // CPU responder: answers each request after resp_wait cycles unless held
   initial begin
      forever begin
         @(negedge clk);
         load_resp = 1'b0;
         if (reset && request && !hold) begin
            if (resp_cnt >= resp_wait) begin
               if (addr_q.size() == 0) fail("unexpected_request", 32'(addressout));
               else check("request_addr", 32'(addressout), 32'(addr_q.pop_front()));
               in_resp   = mem.exists(addressout) ? mem[addressout] : 30'd0;
               load_resp = 1'b1;
               resp_cnt  = 0;
            end else begin
               resp_cnt++;
            end
         end else begin
            resp_cnt = 0;
         end
      end
   end

   // UART receiver: samples mid-bit; frames cut short by reset are discarded
   initial begin
      logic [7:0] b;
      logic sb, st;
      int ab;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            ab = abort_cnt;
            frames_started++;
            repeat (BD/2 - 1) @(negedge clk);
            sb = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge clk);
               b[i] = tx;
            end
            repeat (BD) @(negedge clk);
            st = tx;
            if (ab == abort_cnt) begin
               bytes_seen++;
               check("tx_framing", {30'd0, sb, st}, 32'd1);
               if (exp_q.size() == 0) fail("unexpected_byte", 32'(b));
               else check("tx_byte", 32'(b), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      stop_exp_t e;
      forever begin
         @(negedge clk);
         if (stop === 1'b1) begin
            if (stop_q.size() == 0) fail("unexpected_stop", 32'(addressout));
            else begin
               e = stop_q.pop_front();
               check("stop_addr", 32'(addressout), 32'(e.addr));
               if (e.bytes >= 0) check("stop_after_block", 32'(bytes_seen), 32'(e.bytes));
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (busy !== 1'b1) busy_low_cnt++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, low0, bad, n, k;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_request", 32'(request), 32'd0);
      check("rst_stop", 32'(stop), 32'd0);
      check("rst_addressout", 32'(addressout), 32'd0);
      check("rst_tx", 32'(tx), 32'd1);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // 1: basic block, plus a stray load mid-send that must be ignored
      resp_wait = 0;
      push_block(12'd100, mkw(1, 2, 3, 4, 5), mkw(30, 31, 32, 33, 0));
      push5(40'h4142434445);
      push5(40'h3031323320);
      push_eol();
      idle_start(12'd100);
      wait_bytes("t1_two_bytes", 2, 500);
      @(negedge clk);
      in_stray = '1;
      load_stray = 1'b1;
      @(negedge clk);
      load_stray = 1'b0;
      wait_done("t1_done", 3000);

      // 2: unmapped codes and punctuation
      resp_wait = 3;
      push_block(12'd300, mkw(10, 20, 21, 56, 63), mkw(55, 52, 49, 48, 53));
      push5(40'h3F3F3F3F3F);
      push5(40'h2740243D3B);
      push_eol();
      idle_start(12'd300);
      wait_done("t2_done", 3000);

      // 3: chained block; a second busy start while pending is ignored
      resp_wait = 1;
      base = bytes_seen;
      push_block(12'd400, mkw(8, 9, 11, 12, 13), mkw(14, 15, 16, 17, 18));
      push_block(12'd200, mkw(19, 22, 23, 24, 25), mkw(26, 27, 28, 29, 0));
      push5(40'h48494A4B4C);
      push5(40'h4D4E4F5051);
      push_eol();
      push5(40'h5253545556);
      push5(40'h5758595A20);
      push_eol();
      idle_start(12'd400);
      low0 = busy_low_cnt;
      wait_bytes("t3_three_bytes", base + 3, 500);
      stop_q.push_back('{addr: 12'd200, bytes: base + 12});
      do_start(12'd200);
      check("t3_no_stop_busy_start", 32'(stop), 32'd0);
      do_start(12'd777);
      check("t3_no_stop_pending_start", 32'(stop), 32'd0);
      wait_bytes("t3_all_bytes", base + 24, 4000);
      check("t3_busy_held", 32'(busy_low_cnt), 32'(low0));
      wait_done("t3_done", 3000);

      // 4: address wrap, then a stray load while idle
      resp_wait = 0;
      push_block(12'd4095, mkw(40, 41, 42, 43, 44), mkw(45, 46, 47, 50, 51));
      push5(40'h2E2C28292B);
      push5(40'h2D2A2F3C3E);
      push_eol();
      idle_start(12'd4095);
      wait_done("t4_done", 3000);
      @(negedge clk);
      in_stray = 30'h12345678;
      load_stray = 1'b1;
      @(negedge clk);
      load_stray = 1'b0;
      @(negedge clk);
      check("stray_busy", 32'(busy), 32'd0);
      check("stray_request", 32'(request), 32'd0);
      check("stray_addressout", 32'(addressout), 32'd1);
      check("stray_tx", 32'(tx), 32'd1);

      // 5: CPU stalls for 50 cycles in FETCH
      hold = 1'b1;
      base = bytes_seen;
      push_block(12'd10, mkw(54, 39, 38, 1, 2), mkw(3, 4, 5, 6, 7));
      push5(40'h3A39384142);
      push5(40'h4344454647);
      push_eol();
      idle_start(12'd10);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (request !== 1'b1 || tx !== 1'b1) bad++;
      end
      check("t5_hold_req_tx", 32'(bad), 32'd0);
      check("t5_no_bytes", 32'(bytes_seen), 32'(base));
      hold = 1'b0;
      k = 0;
      while (request === 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n = 0;
      while (tx !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t5_latency_ok", {31'd0, (n <= 3)}, 32'd1);
      wait_done("t5_done", 3000);

      // 6: reset in the middle of char 2, then a fresh block
      base = frames_started;
      mem[12'd500] = mkw(9, 8, 7, 6, 5);
      addr_q.push_back(12'd500);
      exp_q.push_back(8'h49);
      exp_q.push_back(8'h48);
      idle_start(12'd500);
      k = 0;
      while (frames_started < base + 3 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("t6_third_frame", 32'(frames_started), 32'(base + 3));
      repeat (4*BD + BD/2) @(negedge clk);
      reset = 1'b0;
      abort_cnt++;
      @(negedge clk);
      check("t6_rst_tx", 32'(tx), 32'd1);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_request", 32'(request), 32'd0);
      check("t6_rst_addressout", 32'(addressout), 32'd0);
      check("t6_first_bytes", 32'(exp_q.size()), 32'd0);
      reset = 1'b1;
      addr_q.delete();
      stop_q.delete();
      exp_q.delete();
      repeat (12*BD) @(negedge clk);
      push_block(12'd600, mkw(34, 35, 36, 37, 0), mkw(1, 1, 1, 1, 1));
      push5(40'h3435363720);
      push5(40'h4141414141);
      push_eol();
      idle_start(12'd600);
      wait_done("t6_done", 3000);

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
